// File: rtl/zsdram_arb_pkg.sv
// Shared constants and state encoding for the SDRAM burst-port round-robin arbiter.
package zsdram_arb_pkg;

    localparam int NPORT       = 4;
    localparam int BURST       = 4;
    localparam int ADDR_W_DEF  = 24;
    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/zsdram_rr_arbiter_if.sv
// Client-side and controller-side signals of the arbiter; slave is the arbiter's view.
interface zsdram_rr_arbiter_if
    import zsdram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic                              en;
    logic [NPORT-1:0]                  iReq;
    logic [NPORT-1:0]                  iWe;
    logic [NPORT*ADDR_W-1:0]           iAddr;
    logic [NPORT*BURST*DATA_W-1:0]     iWData;
    logic [NPORT-1:0]                  oDone;
    logic                              oErr;
    logic [BURST*DATA_W-1:0]           oRData;
    logic                              oBusy;
    logic [NPORT-1:0]                  oGrant;
    logic [NPORT-1:0]                  oTo_Flag;
    logic                              oCmd_Req;
    logic                              oCmd_We;
    logic [ADDR_W-1:0]                 oCmd_Addr;
    logic [BURST*DATA_W-1:0]           oCmd_WData;
    logic                              iCmd_Done;
    logic [BURST*DATA_W-1:0]           iCmd_RData;

    modport slave (
        input  en, iReq, iWe, iAddr, iWData, iCmd_Done, iCmd_RData,
        output oDone, oErr, oRData, oBusy, oGrant, oTo_Flag,
               oCmd_Req, oCmd_We, oCmd_Addr, oCmd_WData
    );

    modport master (
        output en, iReq, iWe, iAddr, iWData, iCmd_Done, iCmd_RData,
        input  oDone, oErr, oRData, oBusy, oGrant, oTo_Flag,
               oCmd_Req, oCmd_We, oCmd_Addr, oCmd_WData
    );

endinterface

// File: rtl/zsdram_rr_pick.sv
// Combinational round-robin picker: rotate so last+1 is bit 0, take the lowest set bit, rotate back.
module zsdram_rr_pick
    import zsdram_arb_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  logic [1:0]       last,
    output logic [NPORT-1:0] onehot,
    output logic [1:0]       idx,
    output logic             valid
);

    logic [1:0]         base;
    logic [2*NPORT-2:0] dbl;
    logic [NPORT-1:0]   rot;
    logic [1:0]         sel;

    assign base = last + 2'd1;
    assign dbl  = {req[NPORT-2:0], req};
    assign rot  = dbl[base +: NPORT];

    always_comb begin
        sel = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (rot[i]) begin
                sel = 2'(i);
            end
        end
    end

    assign idx    = base + sel;
    assign valid  = |req;
    assign onehot = valid ? (NPORT'(1) << idx) : '0;

endmodule

// File: rtl/zsdram_rr_arbiter.sv
// Four-port round-robin arbiter for a shared SDRAM 4-word burst command port, with watchdog and done pulses.
module zsdram_rr_arbiter
    import zsdram_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
)(
    input  logic                clk,
    input  logic                rst,
    zsdram_rr_arbiter_if.slave  bus
);

    localparam int BW   = BURST * DATA_W;
    localparam int WD_W = $clog2(TIMEOUT);

    state_t             state, state_n;
    logic [1:0]         last, last_n;
    logic [WD_W-1:0]    wdog, wdog_n;
    logic [NPORT-1:0]   grant, grant_n;
    logic [NPORT-1:0]   done, done_n;
    logic [NPORT-1:0]   to_flag, to_flag_n;
    logic               err, err_n;
    logic               busy, busy_n;
    logic               cmd_req, cmd_req_n;
    logic               cmd_we, cmd_we_n;
    logic [ADDR_W-1:0]  cmd_addr, cmd_addr_n;
    logic [BW-1:0]      cmd_wdata, cmd_wdata_n;
    logic [BW-1:0]      rdata, rdata_n;

    logic [NPORT-1:0]   pick_onehot;
    logic [1:0]         pick_idx;
    logic               pick_valid;

    zsdram_rr_pick u_pick (
        .req    (bus.iReq),
        .last   (last),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        state_n     = state;
        last_n      = last;
        wdog_n      = wdog;
        grant_n     = grant;
        done_n      = done;
        to_flag_n   = to_flag;
        err_n       = err;
        cmd_req_n   = cmd_req;
        cmd_we_n    = cmd_we;
        cmd_addr_n  = cmd_addr;
        cmd_wdata_n = cmd_wdata;
        rdata_n     = rdata;

        case (state)
            IDLE: begin
                if (bus.en && pick_valid) begin
                    grant_n     = pick_onehot;
                    cmd_we_n    = bus.iWe[pick_idx];
                    cmd_addr_n  = bus.iAddr[pick_idx*ADDR_W +: ADDR_W];
                    cmd_wdata_n = bus.iWData[pick_idx*BW +: BW];
                    cmd_req_n   = 1'b1;
                    last_n      = pick_idx;
                    wdog_n      = '0;
                    state_n     = ISSUE;
                end
            end
            ISSUE: begin
                // A real completion takes precedence over a watchdog expiry in the same cycle.
                if (bus.iCmd_Done) begin
                    cmd_req_n = 1'b0;
                    if (!cmd_we) begin
                        rdata_n = bus.iCmd_RData;
                    end
                    done_n  = grant;
                    state_n = GAP;
                end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    cmd_req_n = 1'b0;
                    done_n    = grant;
                    err_n     = 1'b1;
                    to_flag_n = to_flag | grant;
                    state_n   = GAP;
                end else begin
                    wdog_n = wdog + WD_W'(1);
                end
            end
            GAP: begin
                done_n  = '0;
                err_n   = 1'b0;
                grant_n = '0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 2'd3;
            wdog      <= '0;
            grant     <= '0;
            done      <= '0;
            to_flag   <= '0;
            err       <= 1'b0;
            busy      <= 1'b0;
            cmd_req   <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            rdata     <= '0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            wdog      <= wdog_n;
            grant     <= grant_n;
            done      <= done_n;
            to_flag   <= to_flag_n;
            err       <= err_n;
            busy      <= busy_n;
            cmd_req   <= cmd_req_n;
            cmd_we    <= cmd_we_n;
            cmd_addr  <= cmd_addr_n;
            cmd_wdata <= cmd_wdata_n;
            rdata     <= rdata_n;
        end
    end

    assign bus.oDone      = done;
    assign bus.oErr       = err;
    assign bus.oRData     = rdata;
    assign bus.oBusy      = busy;
    assign bus.oGrant     = grant;
    assign bus.oTo_Flag   = to_flag;
    assign bus.oCmd_Req   = cmd_req;
    assign bus.oCmd_We    = cmd_we;
    assign bus.oCmd_Addr  = cmd_addr;
    assign bus.oCmd_WData = cmd_wdata;

endmodule

// File: tb/tb_zsdram_rr_arbiter.sv
// Self-checking bench for zsdram_rr_arbiter: directed scenarios plus randomized commands against a transaction-level model.
module tb_zsdram_rr_arbiter;

    localparam int AW = 24;
    localparam int DW = 16;
    localparam int TO = 8;
    localparam int BW = 4 * DW;

    logic clk = 1'b0;
    logic rst;

    zsdram_rr_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    zsdram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          model_last;
    logic [3:0]  model_to_flag;
    logic [63:0] model_rdata;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Next owner: first requester at last+1, last+2, ... modulo 4.
    function automatic int modelPick(input logic [3:0] req);
        for (int k = 1; k <= 4; k++) begin
            if (req[(model_last + k) % 4]) return (model_last + k) % 4;
        end
        return -1;
    endfunction

    task automatic applyStimulus(input logic [3:0] req);
        bus.iReq = req;
        for (int p = 0; p < 4; p++) begin
            bus.iWe[p]              = 1'($urandom_range(0, 1));
            bus.iAddr[p*AW +: AW]   = AW'($urandom);
            bus.iWData[p*BW +: BW]  = {$urandom, $urandom};
        end
    endtask

    task automatic resetDut();
        rst            = 1'b1;
        bus.en         = 1'b0;
        bus.iReq       = '0;
        bus.iWe        = '0;
        bus.iAddr      = '0;
        bus.iWData     = '0;
        bus.iCmd_Done  = 1'b0;
        bus.iCmd_RData = '0;
        model_last     = 3;
        model_to_flag  = '0;
        model_rdata    = '0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        bus.en = 1'b1;
    endtask

    // One full grant/ISSUE/GAP cycle; lat = cycle of iCmd_Done after the grant (0 = never answered).
    task automatic runCommand(input int lat, input bit drop, input bit scramble,
                              input bit en_low, input logic [63:0] rd);
        int          w;
        int          n;
        bit          is_to;
        logic [3:0]  oh;
        logic        we;
        logic [AW-1:0] ad;
        logic [BW-1:0] wd;

        w = modelPick(bus.iReq);
        if (w < 0) w = 0;
        oh = 4'(1 << w);
        we = bus.iWe[w];
        ad = bus.iAddr[w*AW +: AW];
        wd = bus.iWData[w*BW +: BW];
        is_to = (lat == 0);
        n = is_to ? TO : lat;

        @(negedge clk);
        model_last = w;
        checkOutput("grant",      64'(bus.oGrant),     64'(oh));
        checkOutput("cmd_req",    64'(bus.oCmd_Req),   64'(1));
        checkOutput("cmd_we",     64'(bus.oCmd_We),    64'(we));
        checkOutput("cmd_addr",   64'(bus.oCmd_Addr),  64'(ad));
        checkOutput("cmd_wdata",  bus.oCmd_WData,      wd);
        checkOutput("busy_issue", 64'(bus.oBusy),      64'(1));
        checkOutput("done_issue", 64'(bus.oDone),      64'(0));

        if (scramble) begin
            bus.iWData[w*BW +: BW] = ~wd;
            bus.iAddr[w*AW +: AW]  = ~ad;
            bus.iWe[w]             = ~we;
            bus.iReq[w]            = 1'b0;
        end
        if (en_low) bus.en = 1'b0;

        for (int c = 1; c < n; c++) begin
            @(negedge clk);
            checkOutput("issue_hold_req",   64'(bus.oCmd_Req),  64'(1));
            checkOutput("issue_hold_addr",  64'(bus.oCmd_Addr), 64'(ad));
            checkOutput("issue_hold_wdata", bus.oCmd_WData,     wd);
        end
        if (!is_to) begin
            bus.iCmd_Done  = 1'b1;
            bus.iCmd_RData = rd;
        end

        @(negedge clk);
        bus.iCmd_Done = 1'b0;
        if (!is_to && !we) model_rdata = rd;
        if (is_to) model_to_flag = model_to_flag | oh;
        checkOutput("done_pulse",   64'(bus.oDone),    64'(oh));
        checkOutput("err_pulse",    64'(bus.oErr),     64'(is_to));
        checkOutput("req_dropped",  64'(bus.oCmd_Req), 64'(0));
        checkOutput("grant_gap",    64'(bus.oGrant),   64'(oh));
        checkOutput("rdata_done",   bus.oRData,        model_rdata);
        checkOutput("to_flag_done", 64'(bus.oTo_Flag), 64'(model_to_flag));

        if (drop) bus.iReq[w] = 1'b0;
        bus.iCmd_Done  = 1'b1;
        bus.iCmd_RData = ~rd;

        @(negedge clk);
        bus.iCmd_Done = 1'b0;
        if (en_low) bus.en = 1'b1;
        checkOutput("done_cleared",  64'(bus.oDone),    64'(0));
        checkOutput("err_cleared",   64'(bus.oErr),     64'(0));
        checkOutput("grant_idle",    64'(bus.oGrant),   64'(0));
        checkOutput("busy_idle",     64'(bus.oBusy),    64'(0));
        checkOutput("req_idle",      64'(bus.oCmd_Req), 64'(0));
        checkOutput("rdata_held",    bus.oRData,        model_rdata);
        checkOutput("to_flag_held",  64'(bus.oTo_Flag), 64'(model_to_flag));
    endtask

    initial begin
        $display("[TB] start");
        resetDut();

        // Reset values
        checkOutput("rst_done",  64'(bus.oDone),     64'(0));
        checkOutput("rst_err",   64'(bus.oErr),      64'(0));
        checkOutput("rst_rdata", bus.oRData,         64'(0));
        checkOutput("rst_busy",  64'(bus.oBusy),     64'(0));
        checkOutput("rst_grant", 64'(bus.oGrant),    64'(0));
        checkOutput("rst_flag",  64'(bus.oTo_Flag),  64'(0));
        checkOutput("rst_req",   64'(bus.oCmd_Req),  64'(0));
        checkOutput("rst_addr",  64'(bus.oCmd_Addr), 64'(0));

        // Single read from port 0
        applyStimulus(4'b0001);
        bus.iWe[0]        = 1'b0;
        bus.iAddr[0 +: AW] = 24'h000100;
        runCommand(1, 1, 0, 0, 64'h4444_3333_2222_1111);

        // Round robin with all ports held
        resetDut();
        applyStimulus(4'b1111);
        for (int i = 0; i < 5; i++) runCommand(3, 0, 0, 0, {$urandom, $urandom});

        // Write latching with inputs changed mid-command
        applyStimulus(4'b0100);
        bus.iWe[2]              = 1'b1;
        bus.iAddr[2*AW +: AW]   = 24'h00ABCD;
        bus.iWData[2*BW +: BW]  = 64'hDEAD_BEEF_0123_4567;
        runCommand(2, 1, 1, 0, {$urandom, $urandom});

        // Timeout on a port 3 read
        applyStimulus(4'b1000);
        bus.iWe[3] = 1'b0;
        runCommand(0, 1, 0, 0, {$urandom, $urandom});

        // Enable gating
        bus.en = 1'b0;
        applyStimulus(4'b0010);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("en_gate_grant", 64'(bus.oGrant),   64'(0));
            checkOutput("en_gate_req",   64'(bus.oCmd_Req), 64'(0));
            checkOutput("en_gate_busy",  64'(bus.oBusy),    64'(0));
        end
        bus.en = 1'b1;
        runCommand(1, 1, 0, 0, {$urandom, $urandom});

        // Done coinciding with the watchdog's last cycle
        applyStimulus(4'b0001);
        bus.iWe[0] = 1'b0;
        runCommand(TO, 1, 0, 0, {$urandom, $urandom});

        // Randomized commands
        for (int i = 0; i < 24; i++) begin
            applyStimulus(4'($urandom_range(1, 15)));
            runCommand(int'($urandom_range(0, TO)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       {$urandom, $urandom});
        end

        // Reset in the middle of ISSUE
        applyStimulus(4'b0001);
        @(negedge clk);
        checkOutput("pre_rst_req", 64'(bus.oCmd_Req), 64'(1));
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_req",   64'(bus.oCmd_Req), 64'(0));
        checkOutput("async_rst_busy",  64'(bus.oBusy),    64'(0));
        checkOutput("async_rst_grant", 64'(bus.oGrant),   64'(0));
        checkOutput("async_rst_flag",  64'(bus.oTo_Flag), 64'(0));
        applyStimulus(4'b1010);
        model_last    = 3;
        model_to_flag = '0;
        model_rdata   = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("rst_no_done", 64'(bus.oDone), 64'(0));
        end
        rst = 1'b0;
        runCommand(2, 1, 0, 0, {$urandom, $urandom});
        runCommand(2, 1, 0, 0, {$urandom, $urandom});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
